apb4_master: RTL and testbench

- APB4 initiator that turns a simple valid/ready request/response interface into APB4 SETUP/ACCESS transfers.
- Drives on-chip APB4 slaves such as the interrupt controller and the peripheral register banks from a bus bridge or a debug/DMA agent.
- Handles one outstanding transfer at a time.
- Supports slave wait states, captures PSLVERR, and has a configurable ACCESS-phase timeout.

---
 rtl/apb4_master.sv | 182 ++++++++++++++++++
 tb/tb_apb4_master.sv | 355 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb4_master.sv
// ============================================================================
// Module   : apb4_master
// Brief    : Valid/ready request/response to APB4 initiator, one transfer at a
//            time, with wait-state support, PSLVERR capture and ACCESS timeout.
// Revision : 1.0
// ============================================================================
`default_nettype none

module apb4_master #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 255
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    req_valid_i,
  output logic                    req_ready_o,
  input  logic                    req_write_i,
  input  logic [ADDR_WIDTH-1:0]   req_addr_i,
  input  logic [DATA_WIDTH-1:0]   req_wdata_i,
  input  logic [DATA_WIDTH/8-1:0] req_strb_i,
  input  logic [2:0]              req_prot_i,
  output logic                    rsp_valid_o,
  input  logic                    rsp_ready_i,
  output logic [DATA_WIDTH-1:0]   rsp_rdata_o,
  output logic                    rsp_err_o,
  output logic                    rsp_timeout_o,
  output logic [ADDR_WIDTH-1:0]   paddr_o,
  output logic [2:0]              pprot_o,
  output logic                    psel_o,
  output logic                    penable_o,
  output logic                    pwrite_o,
  output logic [DATA_WIDTH-1:0]   pwdata_o,
  output logic [DATA_WIDTH/8-1:0] pstrb_o,
  input  logic                    pready_i,
  input  logic [DATA_WIDTH-1:0]   prdata_i,
  input  logic                    pslverr_i
);

  localparam int STRB_WIDTH = DATA_WIDTH / 8;
  localparam int CNT_WIDTH  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam bit TMO_EN     = (TIMEOUT > 0);

  localparam logic [CNT_WIDTH-1:0] CNT_MAX  = {CNT_WIDTH{1'b1}};
  localparam logic [CNT_WIDTH-1:0] CNT_LAST = (TIMEOUT > 0) ? CNT_WIDTH'(TIMEOUT - 1) : '0;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SETUP  = 2'd1;
  localparam logic [1:0] S_ACCESS = 2'd2;
  localparam logic [1:0] S_RESP   = 2'd3;

  logic [1:0]            state_q,       state_d;
  logic [CNT_WIDTH-1:0]  cnt_q,         cnt_d;
  logic [ADDR_WIDTH-1:0] paddr_q,       paddr_d;
  logic [2:0]            pprot_q,       pprot_d;
  logic                  pwrite_q,      pwrite_d;
  logic [DATA_WIDTH-1:0] pwdata_q,      pwdata_d;
  logic [STRB_WIDTH-1:0] pstrb_q,       pstrb_d;
  logic                  psel_q,        psel_d;
  logic                  penable_q,     penable_d;
  logic                  rsp_valid_q,   rsp_valid_d;
  logic [DATA_WIDTH-1:0] rsp_rdata_q,   rsp_rdata_d;
  logic                  rsp_err_q,     rsp_err_d;
  logic                  rsp_timeout_q, rsp_timeout_d;

  logic accept;
  logic timeout_hit;

  assign accept      = req_valid_i && (state_q == S_IDLE);
  // The cycle that would bring the wait count up to TIMEOUT is the last one allowed.
  assign timeout_hit = TMO_EN && (cnt_q == CNT_LAST);

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    paddr_d       = paddr_q;
    pprot_d       = pprot_q;
    pwrite_d      = pwrite_q;
    pwdata_d      = pwdata_q;
    pstrb_d       = pstrb_q;
    rsp_rdata_d   = rsp_rdata_q;
    rsp_err_d     = rsp_err_q;
    rsp_timeout_d = rsp_timeout_q;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          paddr_d  = req_addr_i;
          pprot_d  = req_prot_i;
          pwrite_d = req_write_i;
          pwdata_d = req_wdata_i;
          pstrb_d  = req_write_i ? req_strb_i : '0;
          cnt_d    = '0;
          state_d  = S_SETUP;
        end
      end
      S_SETUP: begin
        state_d = S_ACCESS;
      end
      S_ACCESS: begin
        if (pready_i) begin
          rsp_rdata_d   = pwrite_q ? '0 : prdata_i;
          rsp_err_d     = pslverr_i;
          rsp_timeout_d = 1'b0;
          state_d       = S_RESP;
        end else begin
          if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + 1'b1;
          end
          if (timeout_hit) begin
            rsp_rdata_d   = '0;
            rsp_err_d     = 1'b1;
            rsp_timeout_d = 1'b1;
            state_d       = S_RESP;
          end
        end
      end
      S_RESP: begin
        if (rsp_ready_i) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Bus controls are registered from the next state so they are glitch-free.
    psel_d      = (state_d == S_SETUP) || (state_d == S_ACCESS);
    penable_d   = (state_d == S_ACCESS);
    rsp_valid_d = (state_d == S_RESP);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      paddr_q       <= '0;
      pprot_q       <= '0;
      pwrite_q      <= 1'b0;
      pwdata_q      <= '0;
      pstrb_q       <= '0;
      psel_q        <= 1'b0;
      penable_q     <= 1'b0;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_err_q     <= 1'b0;
      rsp_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      paddr_q       <= paddr_d;
      pprot_q       <= pprot_d;
      pwrite_q      <= pwrite_d;
      pwdata_q      <= pwdata_d;
      pstrb_q       <= pstrb_d;
      psel_q        <= psel_d;
      penable_q     <= penable_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_rdata_q   <= rsp_rdata_d;
      rsp_err_q     <= rsp_err_d;
      rsp_timeout_q <= rsp_timeout_d;
    end
  end

  // Gated with reset so the ready output reads 0 while reset is held.
  assign req_ready_o   = (state_q == S_IDLE) && !rst_i;
  assign rsp_valid_o   = rsp_valid_q;
  assign rsp_rdata_o   = rsp_rdata_q;
  assign rsp_err_o     = rsp_err_q;
  assign rsp_timeout_o = rsp_timeout_q;
  assign paddr_o       = paddr_q;
  assign pprot_o       = pprot_q;
  assign psel_o        = psel_q;
  assign penable_o     = penable_q;
  assign pwrite_o      = pwrite_q;
  assign pwdata_o      = pwdata_q;
  assign pstrb_o       = pstrb_q;

endmodule

`default_nettype wire

// File: tb/tb_apb4_master.sv
// ============================================================================
// Module   : tb_apb4_master
// Brief    : Scoreboard bench for apb4_master with an APB4 slave model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_apb4_master;

  localparam int TMO = 4;

  typedef struct {
    logic        write;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    logic [2:0]  prot;
    int          waits;
    logic [31:0] prdata;
    logic        slverr;
  } txn_t;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    logic        tmo;
  } rsp_t;

  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic        req_valid_i = 1'b0;
  logic        req_ready_o;
  logic        req_write_i = 1'b0;
  logic [31:0] req_addr_i = '0;
  logic [31:0] req_wdata_i = '0;
  logic [3:0]  req_strb_i = '0;
  logic [2:0]  req_prot_i = '0;
  logic        rsp_valid_o;
  logic        rsp_ready_i = 1'b0;
  logic [31:0] rsp_rdata_o;
  logic        rsp_err_o;
  logic        rsp_timeout_o;
  logic [31:0] paddr_o;
  logic [2:0]  pprot_o;
  logic        psel_o;
  logic        penable_o;
  logic        pwrite_o;
  logic [31:0] pwdata_o;
  logic [3:0]  pstrb_o;
  logic        pready_i = 1'b0;
  logic [31:0] prdata_i = '0;
  logic        pslverr_i = 1'b0;

  int vec_cnt = 0;
  int err_cnt = 0;

  txn_t apb_q[$];
  rsp_t rsp_q[$];

  bit rr_random = 1'b0;
  bit rr_force  = 1'b1;

  apb4_master #(
    .ADDR_WIDTH(32),
    .DATA_WIDTH(32),
    .TIMEOUT   (TMO)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst_i),
    .req_valid_i  (req_valid_i),
    .req_ready_o  (req_ready_o),
    .req_write_i  (req_write_i),
    .req_addr_i   (req_addr_i),
    .req_wdata_i  (req_wdata_i),
    .req_strb_i   (req_strb_i),
    .req_prot_i   (req_prot_i),
    .rsp_valid_o  (rsp_valid_o),
    .rsp_ready_i  (rsp_ready_i),
    .rsp_rdata_o  (rsp_rdata_o),
    .rsp_err_o    (rsp_err_o),
    .rsp_timeout_o(rsp_timeout_o),
    .paddr_o      (paddr_o),
    .pprot_o      (pprot_o),
    .psel_o       (psel_o),
    .penable_o    (penable_o),
    .pwrite_o     (pwrite_o),
    .pwdata_o     (pwdata_o),
    .pstrb_o      (pstrb_o),
    .pready_i     (pready_i),
    .prdata_i     (prdata_i),
    .pslverr_i    (pslverr_i)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Response-ready driver: random backpressure or a forced level.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      rsp_ready_i = rr_random ? 1'($urandom_range(0, 1)) : rr_force;
    end
  end

  // APB4 slave model: follows the per-transfer wait/data plan queued by stimulus.
  initial begin
    txn_t cur;
    bit   active = 1'b0;
    int   acc = 0;
    int   exp_acc;
    forever begin
      @(negedge clk);
      if (rst_i) begin
        active   = 1'b0;
        acc      = 0;
        pready_i = 1'b0;
      end else if (psel_o && !penable_o) begin
        check("setup_while_busy", 64'(active), 64'd0);
        check("setup_has_plan", 64'(apb_q.size() != 0), 64'd1);
        if (apb_q.size() != 0) begin
          cur    = apb_q.pop_front();
          active = 1'b1;
          acc    = 0;
          check("setup_paddr", 64'(paddr_o), 64'(cur.addr));
          check("setup_pwdata", 64'(pwdata_o), 64'(cur.wdata));
          check("setup_ctl", 64'({pwrite_o, pstrb_o, pprot_o}),
                64'({cur.write, cur.write ? cur.strb : 4'h0, cur.prot}));
        end
        pready_i = 1'b0;
      end else if (psel_o && penable_o && active) begin
        acc++;
        check("access_ctl", 64'({paddr_o, pwrite_o, pstrb_o, pprot_o}),
              64'({cur.addr, cur.write, cur.write ? cur.strb : 4'h0, cur.prot}));
        if (acc > cur.waits) begin
          pready_i  = 1'b1;
          prdata_i  = cur.prdata;
          pslverr_i = cur.slverr;
        end else begin
          // Junk on data/error while not ready: must never be captured.
          pready_i  = 1'b0;
          prdata_i  = $urandom;
          pslverr_i = 1'($urandom_range(0, 1));
        end
      end else begin
        if (active) begin
          exp_acc = (cur.waits >= TMO) ? TMO : cur.waits + 1;
          check("access_cycles", 64'(acc), 64'(exp_acc));
          active = 1'b0;
        end
        pready_i  = 1'b0;
        prdata_i  = $urandom;
        pslverr_i = 1'($urandom_range(0, 1));
      end
    end
  end

  // Response monitor: pops the scoreboard on each handshake, checks hold under stall.
  initial begin
    rsp_t got;
    rsp_t held;
    rsp_t e;
    bit   stalled = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_i || !rsp_valid_o) begin
        stalled = 1'b0;
      end else begin
        got.rdata = rsp_rdata_o;
        got.err   = rsp_err_o;
        got.tmo   = rsp_timeout_o;
        check("rsp_no_psel", 64'({psel_o, penable_o}), 64'd0);
        if (stalled) begin
          check("rsp_hold", 64'({got.rdata, got.err, got.tmo}),
                64'({held.rdata, held.err, held.tmo}));
        end
        if (rsp_ready_i) begin
          check("rsp_expected", 64'(rsp_q.size() != 0), 64'd1);
          if (rsp_q.size() != 0) begin
            e = rsp_q.pop_front();
            check("rsp_rdata", 64'(got.rdata), 64'(e.rdata));
            check("rsp_err_tmo", 64'({got.err, got.tmo}), 64'({e.err, e.tmo}));
          end
          stalled = 1'b0;
        end else begin
          stalled = 1'b1;
          held    = got;
        end
      end
    end
  end

  // Issue one request: record the slave plan and the expected response, then handshake.
  task automatic send(input txn_t t);
    rsp_t e;
    int   n;
    e.tmo   = (t.waits >= TMO);
    e.err   = e.tmo ? 1'b1 : t.slverr;
    e.rdata = (e.tmo || t.write) ? 32'h0 : t.prdata;
    apb_q.push_back(t);
    rsp_q.push_back(e);
    @(posedge clk);
    #1;
    req_valid_i = 1'b1;
    req_write_i = t.write;
    req_addr_i  = t.addr;
    req_wdata_i = t.wdata;
    req_strb_i  = t.strb;
    req_prot_i  = t.prot;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!req_ready_o && n < 300);
    check("req_accept", 64'(req_ready_o), 64'd1);
    @(posedge clk);
    #1;
    req_valid_i = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((rsp_q.size() != 0 || apb_q.size() != 0 || rsp_valid_o || psel_o) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check("drain", 64'(rsp_q.size() + apb_q.size()), 64'd0);
  endtask

  function automatic txn_t mk(input logic w, input logic [31:0] a, input logic [31:0] d,
                              input logic [3:0] s, input int waits, input logic [31:0] rd,
                              input logic err);
    txn_t t;
    t.write  = w;
    t.addr   = a;
    t.wdata  = d;
    t.strb   = s;
    t.prot   = 3'($urandom_range(0, 7));
    t.waits  = waits;
    t.prdata = rd;
    t.slverr = err;
    return t;
  endfunction

  initial begin
    #400000;
    $display("FAIL watchdog: got simulation time limit, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    txn_t t;
    int   n;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_ctl", 64'({req_ready_o, psel_o, penable_o, rsp_valid_o, pwrite_o}), 64'd0);
    check("rst_bus", 64'({paddr_o, pstrb_o, pprot_o}), 64'd0);
    check("rst_rsp", 64'({rsp_rdata_o, rsp_err_o, rsp_timeout_o}), 64'd0);
    rst_i = 1'b0;
    #1;
    check("post_rst_ready", 64'(req_ready_o), 64'd1);

    // Write with zero wait states: latency T+1 SETUP, T+2 ACCESS, T+3 response
    send(mk(1'b1, 32'h1C, 32'h5, 4'hF, 0, 32'h0, 1'b0));
    @(negedge clk);
    check("lat_setup", 64'({psel_o, penable_o, req_ready_o}), 64'b100);
    @(negedge clk);
    check("lat_access", 64'({psel_o, penable_o, pwrite_o, pstrb_o}), 64'b11_1_1111);
    @(negedge clk);
    check("lat_rsp", 64'({rsp_valid_o, psel_o}), 64'b10);
    drain();

    // Read with 3 wait states
    send(mk(1'b0, 32'h14, 32'hABCD, 4'hF, 3, 32'h3, 1'b0));
    drain();

    // Read completing with slave error
    send(mk(1'b0, 32'h20, 32'h0, 4'h0, 1, 32'hDEAD_BEEF, 1'b1));
    drain();

    // Timeout: slave never ready
    send(mk(1'b0, 32'h30, 32'h0, 4'h0, 1000, 32'h1234, 1'b0));
    drain();

    // Response backpressure with a second request pending
    rr_force = 1'b0;
    send(mk(1'b1, 32'h40, 32'h11, 4'h3, 0, 32'h0, 1'b0));
    fork
      send(mk(1'b0, 32'h44, 32'h0, 4'h0, 0, 32'h77, 1'b0));
    join_none
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!rsp_valid_o && n < 50);
    for (int i = 0; i < 5; i++) begin
      check("bp_stall", 64'({rsp_valid_o, req_ready_o, psel_o}), 64'b100);
      if (i < 4) @(negedge clk);
    end
    rr_force = 1'b1;
    @(negedge clk);
    check("bp_handshake", 64'({rsp_valid_o, rsp_ready_i, req_ready_o}), 64'b110);
    @(negedge clk);
    check("bp_idle", 64'({rsp_valid_o, req_ready_o, psel_o}), 64'b010);
    @(negedge clk);
    check("bp_setup", 64'({psel_o, penable_o, paddr_o}), {2'b10, 32'h44});
    drain();

    // Reset asserted mid-ACCESS
    send(mk(1'b1, 32'h50, 32'h99, 4'h1, 3, 32'h0, 1'b0));
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!penable_o && n < 50);
    #2;
    rst_i = 1'b1;
    rsp_q.delete();
    #1;
    check("rst_async_drop", 64'({psel_o, penable_o, req_ready_o}), 64'd0);
    repeat (3) @(negedge clk);
    check("rst_no_rsp", 64'({rsp_valid_o, psel_o}), 64'd0);
    rst_i = 1'b0;
    #1;
    check("rst_release_ready", 64'(req_ready_o), 64'd1);
    repeat (2) @(negedge clk);
    check("rst_still_no_rsp", 64'(rsp_valid_o), 64'd0);
    send(mk(1'b0, 32'h54, 32'h0, 4'h0, 0, 32'hCAFE_F00D, 1'b0));
    drain();

    // Randomized traffic with random backpressure
    rr_random = 1'b1;
    for (int i = 0; i < 60; i++) begin
      t = mk(1'($urandom_range(0, 1)), $urandom, $urandom, 4'($urandom_range(0, 15)),
             int'($urandom_range(0, 6)), $urandom, 1'($urandom_range(0, 1)));
      send(t);
    end
    drain();
    rr_random = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule

`default_nettype wire
